game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
Top-level round controller for the symbol-counting game. Sequences countdown, play period, answer entry and result display over NUM_ROUNDS rounds. Pulses gameSig to start the play period and waits for its answerSig. Collects the player's guess from buttons, compares it with numSpecial and keeps the score.

Parameters:
NUM_ROUNDS, 3, rounds per game (1..15)
COUNTDOWN_S, 3, seconds of countdown before each play period
ANSWER_S, 10, seconds allowed for guess entry
RESULT_S, 2, seconds the result is shown
PLAY_TIMEOUT_S, 20, watchdog limit for answerSig after gameSig

Ports:
Clk100M  in  1  system clock, 100 MHz
Reset  in  1  synchronous, active-high reset
Clk1Hz  in  1  1 Hz clock, sampled as data (not used as a clock)
startBtn  in  1  debounced single-cycle pulse
upBtn  in  1  debounced single-cycle pulse, guess +1
downBtn  in  1  debounced single-cycle pulse, guess -1
submitBtn  in  1  debounced single-cycle pulse
answerSig  in  1  single-cycle pulse from play period: period over
numSpecial  in  8  special-symbol count; valid in the answerSig cycle
gameSig  out  1  single-cycle pulse: start play period
state  out  3  current FSM state (encoding in package)
guess  out  8  current player guess
secsLeft  out  8  seconds remaining in the timed state, else 0
round  out  4  current round, 1-based; 0 in IDLE
score  out  4  correct answers this game
correct  out  1  result of the last round; valid in RESULT
timedOut  out  1  last round ended by the play watchdog

Behaviour:
- Reset: state=IDLE; all outputs 0; latched count 0; tick synchroniser flops cleared. Reset mid-game aborts at once; gameSig never fires in a reset cycle.
- secTick: Clk1Hz passes through a 2-flop synchroniser; secTick is a one-cycle pulse on its rising edge. Latency is 3 Clk100M cycles after the edge.
- Timed states: secsLeft is loaded with N on state entry and decrements on each secTick. The exit happens in the cycle of the Nth secTick, when secsLeft goes 1->0.
- IDLE: startBtn -> COUNTDOWN. On this transition, round=1 and score=0.
- COUNTDOWN (N=COUNTDOWN_S): on expiry -> PLAY, with gameSig=1 for exactly that transition cycle.
- PLAY: waits for answerSig. On answerSig, latch numSpecial, clear timedOut, go to ANSWER.
- PLAY watchdog: if PLAY_TIMEOUT_S secTicks pass with no answerSig, set timedOut=1, correct=0 and go to RESULT without scoring. In PLAY, secsLeft shows watchdog seconds remaining.
- ANSWER (N=ANSWER_S): guess=0 on entry.
  - upBtn: +1, saturates at 255. downBtn: -1, saturates at 0. Both in the same cycle: no change.
  - submitBtn or expiry -> RESULT. If submit and expiry coincide, submit wins; the result is the same.
  - An up/down pulse in the exit cycle is ignored.
- RESULT entry: correct = (guess == latched count). score += correct.
- RESULT (N=RESULT_S): on expiry, if round==NUM_ROUNDS -> DONE; else round+1 -> COUNTDOWN.
- DONE: score and round hold. startBtn -> COUNTDOWN with round=1, score=0, guess=0.
- Ignored inputs:
  - startBtn outside IDLE/DONE.
  - answerSig outside PLAY.
  - submitBtn, upBtn, downBtn outside ANSWER.
- Widths: score never exceeds NUM_ROUNDS, so no overflow. secsLeft is 8 bits, and every *_S parameter must be ≤255.

Optional Feature:
Macro HIGH_SCORE_EN.
- Defined: adds output bestScore[3:0], reset to 0.
  - On entry to DONE, bestScore takes score if score > bestScore.
  - Adds output newBest, high for the whole DONE stay when the record was beaten.
  - bestScore is cleared only by Reset.
- Undefined: neither port exists; all other behaviour is identical.

Decomposition:
- Package game_pkg:
  - state enum IDLE=0, COUNTDOWN=1, PLAY=2, ANSWER=3, RESULT=4, DONE=5
  - SYM_W=8, SCORE_W=4, SEC_W=8
- One sub-module, tick_sync: 2-flop synchroniser plus rising-edge pulse generator for Clk1Hz, with Clk100M and Reset.

Test Plan:
1. Reset, then startBtn → COUNTDOWN with secsLeft=3. After 3 secTicks, exactly one gameSig pulse, state=PLAY, round=1.
2. In PLAY, answerSig with numSpecial=7, then 7 upBtn and submitBtn → RESULT, correct=1, score=1.
3. answerSig with numSpecial=4, guess 2, no submit → after 10 secTicks RESULT, correct=0, score unchanged.
4. upBtn and downBtn in the same cycle at guess=0 → guess stays 0. 300 upBtn → guess=255.
5. No answerSig for 20 secTicks → RESULT, timedOut=1, correct=0. Three rounds total → DONE, round=3. startBtn restarts with score=0.
6. Reset asserted during ANSWER → next cycle state=IDLE with all outputs 0. With HIGH_SCORE_EN, game scores 2 then 1 → bestScore=2; newBest only in the first DONE.

Source files
------------

// File: rtl/game_sequencer_pkg.sv
// Shared types and widths for the symbol-counting game round controller.
package game_pkg;

  localparam int SYM_W   = 8;
  localparam int SCORE_W = 4;
  localparam int SEC_W   = 8;
  localparam int ROUND_W = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    PLAY      = 3'd2,
    ANSWER    = 3'd3,
    RESULT    = 3'd4,
    DONE      = 3'd5
  } state_t;

  // States whose exit is driven by the secsLeft countdown.
  function automatic logic is_timed(input state_t s);
    return (s == COUNTDOWN) || (s == PLAY) || (s == ANSWER) || (s == RESULT);
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Handshake between the round controller (master) and the play-period block (slave).
interface game_sequencer_if;
  import game_pkg::*;

  logic             gameSig;
  logic             answerSig;
  logic [SYM_W-1:0] numSpecial;

  modport master (output gameSig, input answerSig, input numSpecial);
  modport slave  (input gameSig, output answerSig, output numSpecial);
endinterface

// File: rtl/game_sequencer_tick_sync.sv
// Synchronises the 1 Hz clock as data and emits a one-cycle pulse per rising edge.
module tick_sync (
  input  logic Clk100M,
  input  logic Reset,
  input  logic Clk1Hz,
  output logic sec_tick
);
  logic s1, s2, s3;

  always_ff @(posedge Clk100M) begin
    if (Reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      sec_tick <= 1'b0;
    end else begin
      s1       <= Clk1Hz;
      s2       <= s1;
      s3       <= s2;
      sec_tick <= s2 & ~s3;
    end
  end
endmodule

// File: rtl/game_sequencer.sv
// Round controller: countdown, play period, guess entry and result display per round.
// Optional HIGH_SCORE_EN adds bestScore/newBest tracking across games.
module game_sequencer
  import game_pkg::*;
#(
  parameter int NUM_ROUNDS     = 3,
  parameter int COUNTDOWN_S    = 3,
  parameter int ANSWER_S       = 10,
  parameter int RESULT_S       = 2,
  parameter int PLAY_TIMEOUT_S = 20
) (
  input  logic               Clk100M,
  input  logic               Reset,
  input  logic               Clk1Hz,
  input  logic               startBtn,
  input  logic               upBtn,
  input  logic               downBtn,
  input  logic               submitBtn,
  game_sequencer_if.master   play,
  output logic [2:0]         state,
  output logic [SYM_W-1:0]   guess,
  output logic [SEC_W-1:0]   secsLeft,
  output logic [ROUND_W-1:0] round,
  output logic [SCORE_W-1:0] score,
  output logic               correct,
  output logic               timedOut
`ifdef HIGH_SCORE_EN
  ,
  output logic [SCORE_W-1:0] bestScore,
  output logic               newBest
`endif
);

  state_t           cur_state, nxt_state;
  logic             sec_tick;
  logic             expire;
  logic             hit;
  logic [SEC_W-1:0] load_secs;
  logic [SYM_W-1:0] count;

  tick_sync u_tick (
    .Clk100M  (Clk100M),
    .Reset    (Reset),
    .Clk1Hz   (Clk1Hz),
    .sec_tick (sec_tick)
  );

  assign expire = sec_tick && is_timed(cur_state) && (secsLeft <= SEC_W'(1));
  assign state  = cur_state;

  always_ff @(posedge Clk100M) begin
    if (Reset) cur_state <= IDLE;
    else       cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      IDLE, DONE: if (startBtn) nxt_state = COUNTDOWN;
      COUNTDOWN:  if (expire) nxt_state = PLAY;
      PLAY: begin
        if (play.answerSig) nxt_state = ANSWER;
        else if (expire)    nxt_state = RESULT;
      end
      ANSWER:     if (submitBtn || expire) nxt_state = RESULT;
      RESULT: begin
        if (expire) nxt_state = (round == ROUND_W'(NUM_ROUNDS)) ? DONE : COUNTDOWN;
      end
      default:    nxt_state = IDLE;
    endcase
  end

  always_comb begin
    play.gameSig = !Reset && (cur_state == COUNTDOWN) && expire;
    hit          = (guess == count);
    case (nxt_state)
      COUNTDOWN: load_secs = SEC_W'(COUNTDOWN_S);
      PLAY:      load_secs = SEC_W'(PLAY_TIMEOUT_S);
      ANSWER:    load_secs = SEC_W'(ANSWER_S);
      RESULT:    load_secs = SEC_W'(RESULT_S);
      default:   load_secs = '0;
    endcase
  end

  always_ff @(posedge Clk100M) begin
    if (Reset) begin
      secsLeft <= '0;
      guess    <= '0;
      round    <= '0;
      score    <= '0;
      correct  <= 1'b0;
      timedOut <= 1'b0;
      count    <= '0;
    end else begin
      if (nxt_state != cur_state)
        secsLeft <= load_secs;
      else if (sec_tick && (secsLeft != '0))
        secsLeft <= secsLeft - SEC_W'(1);

      // Button edits only while staying in ANSWER, so a pulse in the exit cycle is dropped.
      if ((cur_state == ANSWER) && (nxt_state == ANSWER) && (upBtn ^ downBtn)) begin
        if (upBtn && (guess != '1))
          guess <= guess + SYM_W'(1);
        else if (downBtn && (guess != '0))
          guess <= guess - SYM_W'(1);
      end

      case (cur_state)
        IDLE, DONE: begin
          if (nxt_state == COUNTDOWN) begin
            round <= ROUND_W'(1);
            score <= '0;
            guess <= '0;
          end
        end
        PLAY: begin
          if (play.answerSig) begin
            count    <= play.numSpecial;
            timedOut <= 1'b0;
            guess    <= '0;
          end else if (nxt_state == RESULT) begin
            timedOut <= 1'b1;
            correct  <= 1'b0;
          end
        end
        ANSWER: begin
          if (nxt_state == RESULT) begin
            correct <= hit;
            score   <= score + SCORE_W'(hit);
          end
        end
        RESULT: begin
          if (nxt_state == COUNTDOWN) round <= round + ROUND_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef HIGH_SCORE_EN
  always_ff @(posedge Clk100M) begin
    if (Reset) begin
      bestScore <= '0;
      newBest   <= 1'b0;
    end else if ((cur_state == RESULT) && (nxt_state == DONE)) begin
      if (score > bestScore) begin
        bestScore <= score;
        newBest   <= 1'b1;
      end else begin
        newBest   <= 1'b0;
      end
    end else if ((cur_state == DONE) && (nxt_state != DONE)) begin
      newBest <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer; build with HIGH_SCORE_EN to cover best-score tracking.
module tb_game_sequencer;
  import game_pkg::*;

  logic       clk = 1'b0;
  logic       rst, clk1hz, start_b, up_b, down_b, submit_b;
  logic [2:0] st;
  logic [7:0] guess, secs;
  logic [3:0] round, score;
  logic       correct, timed_out;
`ifdef HIGH_SCORE_EN
  logic [3:0] best;
  logic       new_best;
`endif

  int checks   = 0;
  int errors   = 0;
  int gs_count = 0;

  typedef struct {
    logic       up;
    logic       down;
    logic       submit;
    logic [7:0] exp_guess;
    logic [2:0] exp_state;
  } vec_t;
  vec_t vecs[11];

  game_sequencer_if play_if();

  game_sequencer #(
    .NUM_ROUNDS     (3),
    .COUNTDOWN_S    (3),
    .ANSWER_S       (10),
    .RESULT_S       (2),
    .PLAY_TIMEOUT_S (20)
  ) dut (
    .Clk100M   (clk),
    .Reset     (rst),
    .Clk1Hz    (clk1hz),
    .startBtn  (start_b),
    .upBtn     (up_b),
    .downBtn   (down_b),
    .submitBtn (submit_b),
    .play      (play_if),
    .state     (st),
    .guess     (guess),
    .secsLeft  (secs),
    .round     (round),
    .score     (score),
    .correct   (correct),
    .timedOut  (timed_out)
`ifdef HIGH_SCORE_EN
    ,
    .bestScore (best),
    .newBest   (new_best)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (play_if.gameSig === 1'b1) gs_count++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic s, input logic u, input logic d, input logic sub,
                       input logic ans, input logic [7:0] num);
    start_b = s; up_b = u; down_b = d; submit_b = sub;
    play_if.answerSig = ans; play_if.numSpecial = num;
    @(negedge clk);
    start_b = 0; up_b = 0; down_b = 0; submit_b = 0;
    play_if.answerSig = 0; play_if.numSpecial = '0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      clk1hz = 1'b1;
      cyc(4);
      clk1hz = 1'b0;
      cyc(2);
    end
  endtask

  task automatic check_zero(input string name);
    check({name, "_state"}, 32'(st), 32'(IDLE));
    check({name, "_guess"}, 32'(guess), 0);
    check({name, "_secs"}, 32'(secs), 0);
    check({name, "_round"}, 32'(round), 0);
    check({name, "_score"}, 32'(score), 0);
    check({name, "_correct"}, 32'(correct), 0);
    check({name, "_timedout"}, 32'(timed_out), 0);
    check({name, "_gamesig"}, 32'(play_if.gameSig), 0);
  endtask

`ifdef HIGH_SCORE_EN
  task automatic play_round(input int ups);
    tick(3);
    pulse(0, 0, 0, 0, 1, 8'd5);
    for (int i = 0; i < ups; i++) pulse(0, 1, 0, 0, 0, 0);
    pulse(0, 0, 0, 1, 0, 0);
    tick(2);
  endtask
`endif

  initial begin
    for (int i = 0; i < 7; i++) vecs[i] = '{1'b1, 1'b0, 1'b0, 8'(i + 1), ANSWER};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 8'd7, ANSWER};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'd6, ANSWER};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'd7, ANSWER};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 8'd7, RESULT};

    rst = 1; clk1hz = 0; start_b = 0; up_b = 0; down_b = 0; submit_b = 0;
    play_if.answerSig = 0; play_if.numSpecial = '0;
    cyc(3);
    check_zero("reset");
    rst = 0;
    cyc(1);

    // Game 1, round 1: countdown then correct guess
    pulse(0, 0, 0, 0, 1, 8'd9);
    check("idle_ignores_answer", 32'(st), 32'(IDLE));
    pulse(1, 0, 0, 0, 0, 0);
    check("start_state", 32'(st), 32'(COUNTDOWN));
    check("start_secs", 32'(secs), 3);
    check("start_round", 32'(round), 1);
    tick(2);
    check("cd_secs", 32'(secs), 1);
    check("cd_no_gamesig", 32'(gs_count), 0);
    tick(1);
    check("play_state", 32'(st), 32'(PLAY));
    check("play_gamesig_once", 32'(gs_count), 1);
    check("play_watchdog_secs", 32'(secs), 20);
    pulse(0, 0, 0, 0, 1, 8'd7);
    check("answer_state", 32'(st), 32'(ANSWER));
    check("answer_secs", 32'(secs), 10);
    check("answer_guess0", 32'(guess), 0);
    for (int i = 0; i < 11; i++) begin
      pulse(0, vecs[i].up, vecs[i].down, vecs[i].submit, 0, 0);
      check($sformatf("vec%0d_guess", i), 32'(guess), 32'(vecs[i].exp_guess));
      check($sformatf("vec%0d_state", i), 32'(st), 32'(vecs[i].exp_state));
    end
    check("r1_correct", 32'(correct), 1);
    check("r1_score", 32'(score), 1);
    check("r1_result_secs", 32'(secs), 2);
    tick(2);
    check("r2_state", 32'(st), 32'(COUNTDOWN));
    check("r2_round", 32'(round), 2);

    // Round 2: answer expiry with wrong guess; stray answerSig in ANSWER ignored
    tick(3);
    check("r2_gamesig", 32'(gs_count), 2);
    pulse(0, 0, 0, 0, 1, 8'd4);
    pulse(0, 1, 1, 0, 0, 0);
    check("updown_at0", 32'(guess), 0);
    pulse(0, 0, 1, 0, 0, 0);
    check("down_sat0", 32'(guess), 0);
    pulse(0, 1, 0, 0, 0, 0);
    pulse(0, 1, 0, 0, 0, 0);
    pulse(0, 0, 0, 0, 1, 8'd2);
    pulse(1, 0, 0, 0, 0, 0);
    check("r2_guess", 32'(guess), 2);
    check("r2_ignore_start", 32'(st), 32'(ANSWER));
    tick(9);
    check("r2_last_sec", 32'(secs), 1);
    check("r2_still_answer", 32'(st), 32'(ANSWER));
    tick(1);
    check("r2_expire_state", 32'(st), 32'(RESULT));
    check("r2_correct", 32'(correct), 0);
    check("r2_score", 32'(score), 1);
    tick(2);
    check("r3_round", 32'(round), 3);

    // Round 3: play watchdog
    tick(3);
    pulse(0, 1, 0, 1, 0, 0);
    check("play_ignore_btn_state", 32'(st), 32'(PLAY));
    check("play_ignore_btn_guess", 32'(guess), 2);
    tick(19);
    check("wd_last_sec", 32'(secs), 1);
    check("wd_still_play", 32'(st), 32'(PLAY));
    tick(1);
    check("wd_state", 32'(st), 32'(RESULT));
    check("wd_timedout", 32'(timed_out), 1);
    check("wd_correct", 32'(correct), 0);
    check("wd_score", 32'(score), 1);
    tick(2);
    check("done_state", 32'(st), 32'(DONE));
    check("done_round", 32'(round), 3);
    check("done_score", 32'(score), 1);
    check("done_secs", 32'(secs), 0);
`ifdef HIGH_SCORE_EN
    check("g1_best", 32'(best), 1);
    check("g1_newbest", 32'(new_best), 1);
`endif
    pulse(1, 0, 0, 0, 0, 0);
    check("restart_state", 32'(st), 32'(COUNTDOWN));
    check("restart_round", 32'(round), 1);
    check("restart_score", 32'(score), 0);
    check("restart_guess", 32'(guess), 0);

    // Game 2: saturation at 255, then reset mid-ANSWER
    tick(3);
    check("g2_gamesig", 32'(gs_count), 4);
    pulse(0, 0, 0, 0, 1, 8'd255);
    check("g2_timedout_clr", 32'(timed_out), 0);
    for (int i = 0; i < 300; i++) pulse(0, 1, 0, 0, 0, 0);
    check("up_sat255", 32'(guess), 255);
    check("sat_still_answer", 32'(st), 32'(ANSWER));
    rst = 1;
    cyc(1);
    check_zero("midreset");
    check("midreset_no_gamesig", 32'(gs_count), 4);
    rst = 0;
    cyc(1);

`ifdef HIGH_SCORE_EN
    check("hs_reset_best", 32'(best), 0);
    pulse(1, 0, 0, 0, 0, 0);
    play_round(5);
    play_round(5);
    play_round(0);
    check("hsA_state", 32'(st), 32'(DONE));
    check("hsA_score", 32'(score), 2);
    check("hsA_best", 32'(best), 2);
    check("hsA_newbest", 32'(new_best), 1);
    cyc(5);
    check("hsA_newbest_hold", 32'(new_best), 1);
    pulse(1, 0, 0, 0, 0, 0);
    check("hsB_newbest_clr", 32'(new_best), 0);
    play_round(5);
    play_round(0);
    play_round(0);
    check("hsB_state", 32'(st), 32'(DONE));
    check("hsB_score", 32'(score), 1);
    check("hsB_best", 32'(best), 2);
    check("hsB_newbest", 32'(new_best), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
